// File: rtl/memory_controller_32_if.sv
// Request/response bundle between the MAR/MDR datapath stage and the memory controller.
interface memory_controller_32_if;
  logic [31:0] in_mar;
  logic [31:0] in_mdr;
  logic        in_read;
  logic        in_write;
  logic [31:0] out_mem_data;
  logic        out_busy;
  logic        out_done;
  logic        out_fault;

  modport master (
    output in_mar, in_mdr, in_read, in_write,
    input  out_mem_data, out_busy, out_done, out_fault
  );

  modport slave (
    input  in_mar, in_mdr, in_read, in_write,
    output out_mem_data, out_busy, out_done, out_fault
  );
endinterface

// File: rtl/memory_controller_32.sv
// Word-addressed synchronous RAM with WAIT_STATES idle cycles per access and a one-cycle done pulse.
// Optional MEM_BOUNDS_CHECK_EN flags requests whose upper address bits are set and suppresses them.
module memory_controller_32 #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   in_rst_n,
  memory_controller_32_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [ADDR_BITS-1:0]   addr;
  logic [31:0]            wdata;
  logic                   is_write;
  logic                   fault_q;
  logic                   accept;
  logic                   req_fault;
  logic [31:0]            mem_data;
  logic                   busy;
  logic                   done;
  logic                   fault;
  logic [31:0]            ram [DEPTH];

  assign accept = (state == IDLE) && (bus.in_read || bus.in_write);

`ifdef MEM_BOUNDS_CHECK_EN
  assign req_fault = |bus.in_mar[31:ADDR_BITS];
`else
  // Upper address bits alias onto the RAM.
  logic unused_mar_hi;
  assign unused_mar_hi = ^bus.in_mar[31:ADDR_BITS];
  assign req_fault     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      wdata    <= '0;
      is_write <= 1'b0;
      fault_q  <= 1'b0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      fault <= (state_nxt == DONE) && fault_q;
      if (accept) begin
        addr     <= bus.in_mar[ADDR_BITS-1:0];
        wdata    <= bus.in_mdr;
        is_write <= bus.in_write;   // write wins when both strobes are high
        fault_q  <= req_fault;
      end
      if (state == ACCESS && !is_write)
        mem_data <= fault_q ? 32'd0 : ram[addr];
    end
  end

  // RAM has no reset; an aborted access never reaches ACCESS so it is not written.
  always_ff @(posedge clk) begin
    if (state == ACCESS && is_write && !fault_q)
      ram[addr] <= wdata;
  end

  assign bus.out_mem_data = mem_data;
  assign bus.out_busy     = busy;
  assign bus.out_done     = done;
  assign bus.out_fault    = fault;

endmodule

// File: tb/tb_memory_controller_32.sv
// Bench for memory_controller_32: vector table through a scoreboard plus hand-written corner sequences.
module tb_memory_controller_32;

  localparam int WS_A = 2;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic in_rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_controller_32_if ifa ();
  memory_controller_32_if ifb ();

  memory_controller_32 #(.ADDR_BITS(9), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .in_rst_n(in_rst_n), .bus(ifa.slave)
  );
  memory_controller_32 #(.ADDR_BITS(9), .WAIT_STATES(0)) dut_b (
    .clk(clk), .in_rst_n(in_rst_n), .bus(ifb.slave)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] rd;
    logic        flt;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  vec_t        vt [10];
  exp_t        sb [$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic op(input logic w, input logic r, input logic [31:0] mar, input logic [31:0] mdr,
                    input logic [31:0] exp_d, input logic exp_f, input string nm);
    exp_t e;
    int   lat;
    @(negedge clk);
    ifa.in_write = w;
    ifa.in_read  = r;
    ifa.in_mar   = mar;
    ifa.in_mdr   = mdr;
    e.data  = exp_d;
    e.fault = exp_f;
    sb.push_back(e);
    @(posedge clk); #1;
    ifa.in_write = 1'b0;
    ifa.in_read  = 1'b0;
    check({nm, ".busy"}, 32'(ifa.out_busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ifa.out_done) begin
        lat = k;
        break;
      end
    end
    check({nm, ".latency"}, lat, WS_A + 1);
    e = sb.pop_front();
    if (lat != 0) begin
      check({nm, ".data"},  ifa.out_mem_data, e.data);
      check({nm, ".fault"}, 32'(ifa.out_fault), 32'(e.fault));
      @(posedge clk); #1;
      check({nm, ".done_pulse"}, 32'(ifa.out_done), 32'd0);
      check({nm, ".idle"},       32'(ifa.out_busy), 32'd0);
      check({nm, ".held"},       ifa.out_mem_data, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;

    vt[0] = '{1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, "wr_10"};
    vt[1] = '{1'b0, 1'b1, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, "rd_10"};
    vt[2] = '{1'b1, 1'b1, 32'h020, 32'h12345678, 32'h0, 1'b0, "wr_rd_20"};
    vt[3] = '{1'b0, 1'b1, 32'h020, 32'h0, 32'h12345678, 1'b0, "rd_20"};
    vt[4] = '{1'b1, 1'b0, 32'h030, 32'hCAFEF00D, 32'h0, 1'b0, "wr_30"};
    vt[5] = '{1'b1, 1'b0, 32'h210, 32'hA5A5A5A5, 32'h0, BC, "wr_210"};
    vt[6] = '{1'b0, 1'b1, 32'h010, 32'h0, BC ? 32'hDEADBEEF : 32'hA5A5A5A5, 1'b0, "rd_10_alias"};
    vt[7] = '{1'b0, 1'b1, 32'h210, 32'h0, BC ? 32'h0 : 32'hA5A5A5A5, BC, "rd_210"};
    vt[8] = '{1'b1, 1'b0, 32'h1FF, 32'h0F0F0F0F, 32'h0, 1'b0, "wr_1ff"};
    vt[9] = '{1'b0, 1'b1, 32'h1FF, 32'h0, 32'h0F0F0F0F, 1'b0, "rd_1ff"};

    {ifa.in_write, ifa.in_read, ifa.in_mar, ifa.in_mdr} = '0;
    {ifb.in_write, ifb.in_read, ifb.in_mar, ifb.in_mdr} = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.busy",  32'(ifa.out_busy),  32'd0);
    check("reset.done",  32'(ifa.out_done),  32'd0);
    check("reset.fault", 32'(ifa.out_fault), 32'd0);
    check("reset.data",  ifa.out_mem_data,   32'd0);
    @(negedge clk);
    in_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op(vt[i].w, vt[i].r, vt[i].mar, vt[i].mdr,
         vt[i].w ? last_rd : vt[i].rd, vt[i].flt, vt[i].nm);
      if (!vt[i].w) last_rd = vt[i].rd;
    end

    // A read strobe pulsed while the write waits must be dropped.
    @(negedge clk);
    ifa.in_write = 1'b1; ifa.in_mar = 32'h040; ifa.in_mdr = 32'h77777777;
    @(posedge clk); #1;
    ifa.in_write = 1'b0;
    @(negedge clk);
    ifa.in_read = 1'b1;
    @(posedge clk); #1;
    ifa.in_read = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ifa.out_done) n_done++;
    end
    check("wait_ignore.done_count", n_done, 32'd1);
    check("wait_ignore.data", ifa.out_mem_data, last_rd);
    op(1'b0, 1'b1, 32'h040, 32'h0, 32'h77777777, 1'b0, "rd_40");
    last_rd = 32'h77777777;

    // Reset during WAIT aborts the write and clears outputs at once.
    @(negedge clk);
    ifa.in_write = 1'b1; ifa.in_mar = 32'h030; ifa.in_mdr = 32'h11111111;
    @(posedge clk); #1;
    ifa.in_write = 1'b0;
    @(posedge clk); #1;
    in_rst_n = 1'b0;
    #1;
    check("midreset.busy",  32'(ifa.out_busy),  32'd0);
    check("midreset.done",  32'(ifa.out_done),  32'd0);
    check("midreset.data",  ifa.out_mem_data,   32'd0);
    check("midreset.fault", 32'(ifa.out_fault), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ifa.out_done) n_done++;
    end
    check("midreset.no_done", n_done, 32'd0);
    op(1'b0, 1'b1, 32'h030, 32'h0, 32'hCAFEF00D, 1'b0, "rd_30_after_reset");

    // Zero wait states: done in the cycle after the edge following acceptance.
    @(negedge clk);
    ifb.in_write = 1'b1; ifb.in_mar = 32'h010; ifb.in_mdr = 32'hBBBB0000;
    @(posedge clk); #1;
    ifb.in_write = 1'b0;
    check("ws0.wr.busy", 32'(ifb.out_busy), 32'd1);
    check("ws0.wr.not_done_yet", 32'(ifb.out_done), 32'd0);
    @(posedge clk); #1;
    check("ws0.wr.done", 32'(ifb.out_done), 32'd1);
    check("ws0.wr.data", ifb.out_mem_data, 32'd0);
    @(posedge clk); #1;
    check("ws0.wr.done_pulse", 32'(ifb.out_done), 32'd0);
    check("ws0.wr.idle", 32'(ifb.out_busy), 32'd0);
    @(negedge clk);
    ifb.in_read = 1'b1;
    @(posedge clk); #1;
    ifb.in_read = 1'b0;
    @(posedge clk); #1;
    check("ws0.rd.done", 32'(ifb.out_done), 32'd1);
    check("ws0.rd.data", ifb.out_mem_data, 32'hBBBB0000);
    @(posedge clk); #1;
    check("ws0.rd.held", ifb.out_mem_data, 32'hBBBB0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
